f_pc_unit: RTL

- Fetch-stage program counter for the 5-stage MIPS pipeline: owns the PC register and computes next-PC.
- Generalises the existing combinational next-PC logic with:
  - parametrised reset vector, exception vector and address window;
  - stall hold;
  - exception-entry and eret redirects with fixed priority;
  - fetch-address-error detection;
  - a registered delay-slot flag.
- Sits between the F-stage instruction memory and the F/D pipeline register. Consumes redirect information resolved in D and from the CP0 exception logic.

---
 rtl/pc_pkg.sv | 22 ++
 rtl/npc_calc.sv | 38 +++
 rtl/f_pc_unit.sv | 79 +++++++
 3 files changed

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - control-transfer class codes and default vectors for the fetch PC unit
package pc_pkg;

    // Control-transfer class of the instruction sitting in D; codes 3'b100-3'b111 act as PC4
    typedef enum logic [2:0] {
        CLS_PC4 = 3'b000,
        CLS_BR  = 3'b001,
        CLS_J   = 3'b010,
        CLS_JR  = 3'b011
    } pcsrc_e;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_PC   = 32'h0000_4180;
    localparam logic [31:0] DEF_IM_LO    = 32'h0000_3000;
    localparam logic [31:0] DEF_IM_HI    = 32'h0000_6FFF;

    // True for classes that own a delay slot (taken or not)
    function automatic logic has_delay_slot(input logic [2:0] cls);
        return (cls == CLS_BR) || (cls == CLS_J) || (cls == CLS_JR);
    endfunction

endpackage

// File: rtl/npc_calc.sv
// rtl/npc_calc.sv - combinational D-stage redirect target selection
module npc_calc
    import pc_pkg::*;
(
    input  logic [2:0]  d_pcsrc,
    input  logic        d_cond,
    input  logic [31:0] d_pc,
    input  logic [25:0] d_imm26,
    input  logic [31:0] d_rs,
    input  logic [31:0] f_pc,
    output logic [31:0] d_target
);

    logic [31:0] seq_pc;
    logic [31:0] d_pc4;
    logic [31:0] br_pc;
    logic [31:0] j_pc;

    // Candidate targets, all wrapping modulo 2^32
    always_comb begin
        seq_pc = f_pc + 32'd4;
        d_pc4  = d_pc + 32'd4;
        br_pc  = d_pc4 + {{14{d_imm26[15]}}, d_imm26[15:0], 2'b00};
        j_pc   = {d_pc4[31:28], d_imm26, 2'b00};
    end

    // Pick the target for the D instruction's class; a not-taken branch falls through
    always_comb begin
        d_target = seq_pc;
        case (d_pcsrc)
            CLS_BR:  d_target = d_cond ? br_pc : seq_pc;
            CLS_J:   d_target = j_pc;
            CLS_JR:  d_target = d_rs;
            default: d_target = seq_pc;
        endcase
    end

endmodule

// File: rtl/f_pc_unit.sv
// rtl/f_pc_unit.sv - fetch-stage PC register with exception/eret/stall priority and delay-slot flag
module f_pc_unit
    import pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] EXC_PC   = DEF_EXC_PC,
    parameter logic [31:0] IM_LO    = DEF_IM_LO,
    parameter logic [31:0] IM_HI    = DEF_IM_HI
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [2:0]  d_pcsrc,
    input  logic        d_cond,
    input  logic [31:0] d_pc,
    input  logic [25:0] d_imm26,
    input  logic [31:0] d_rs,
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic [31:0] f_pc,
    output logic        f_adel,
    output logic        f_bd,
    output logic [31:0] d_pc8
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        bd_q;
    logic        bd_d;
    logic [31:0] d_target;

    npc_calc u_npc_calc (
        .d_pcsrc  (d_pcsrc),
        .d_cond   (d_cond),
        .d_pc     (d_pc),
        .d_imm26  (d_imm26),
        .d_rs     (d_rs),
        .f_pc     (pc_q),
        .d_target (d_target)
    );

    // Redirect priority: exception entry, then eret, then stall hold, then the D target
    always_comb begin
        pc_d = d_target;
        bd_d = has_delay_slot(d_pcsrc);
        if (exc_req) begin
            pc_d = EXC_PC;
            bd_d = 1'b0;
        end else if (eret) begin
            pc_d = epc;
            bd_d = 1'b0;
        end else if (stall) begin
            pc_d = pc_q;
            bd_d = bd_q;
        end
    end

    // PC and delay-slot flag registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
            bd_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            bd_q <= bd_d;
        end
    end

    // Fetch address error: misaligned or outside the instruction window; PC still advances
    always_comb begin
        f_adel = (pc_q[1:0] != 2'b00) || (pc_q < IM_LO) || (pc_q > IM_HI);
    end

    assign f_pc  = pc_q;
    assign f_bd  = bd_q;
    assign d_pc8 = d_pc + 32'd8;

endmodule
